sdhci_acmd12_arbiter: RTL and testbench
=======================================

Name: sdhci_acmd12_arbiter

Overview:
- Command-issue arbiter between the host driver's command register writes and the Auto CMD12 request raised by the data path.
- Sits between the SDHCI register file and the CMD-line sequencer.
- Orders the two requests, forwards exactly one command at a time, and suppresses the second command when the first response fails.
- Produces the Auto CMD12 Error Status register plus the error/normal interrupt set pulses.

Parameters:
- Acmd12Index, 6'd12, command index used for the automatically issued stop command.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset, synchronous active-high
- drv_cmd_valid_i  in  1  one-cycle pulse: driver wrote the command register
- drv_cmd_i  in  sdhci_cmd_t  driver command: index[5:0], arg[31:0], rsp_type[1:0], crc_chk, idx_chk, data_present
- acmd12_req_i  in  1  one-cycle pulse: last block transferred with auto_cmd12_enable set
- seq_valid_o  out  1  command offered to sequencer
- seq_ready_i  in  1  sequencer accepts command (valid&ready handshake)
- seq_cmd_o  out  sdhci_cmd_t  command offered
- rsp_valid_i  in  1  one-cycle pulse: response phase done
- rsp_err_i  in  sdhci_rsp_err_t  timeout, crc, end_bit, index flags qualified by rsp_valid_i
- cmd_inhibit_o  out  1  high while any command is pending or in flight
- acmd12_status_o  out  16  Auto CMD12 Error Status register value
- err_int_set_o  out  16  one-cycle set pulses into Error Interrupt Status
- cmd_complete_set_o  out  1  one-cycle set pulse, Normal Interrupt Status bit0

Behaviour:
- Reset values:
  - All outputs 0.
  - Pending flags cleared; FSM in IDLE.
- Pending capture:
  - drv_pend is set, and the command latched, on drv_cmd_valid_i.
  - acmd_pend is set on acmd12_req_i.
  - Captures happen in any state.
- FSM states: IDLE, ISSUE_DRV, WAIT_DRV, ISSUE_ACMD, WAIT_ACMD.
- Arbitration from IDLE, deciding on pending flags including same-cycle captures:
  - acmd_pend wins over drv_pend, so simultaneous arrival issues CMD12 first.
  - A request that arrived while the other is in flight waits.
  - Whichever request is pending first when IDLE is reached goes first.
- ISSUE_x:
  - seq_valid_o=1 and seq_cmd_o driven combinationally from state.
  - Hold until seq_ready_i, then move to WAIT_x and clear that request's pending flag.
- CMD12 command format: index Acmd12Index, arg 0, rsp_type 48-bit with busy, crc_chk=1, idx_chk=1, data_present=0.
- WAIT_x: on rsp_valid_i, fail = OR of all rsp_err_i flags.
- WAIT_DRV success:
  - cmd_complete_set_o pulses.
  - Go to IDLE; any pending CMD12 then issues.
- WAIT_DRV fail:
  - err_int_set_o pulses bit0 timeout, bit1 crc, bit2 end_bit, bit3 index, per flag.
  - If acmd_pend: also pulse bit8, load acmd12_status_o = 0x0001 (not executed), clear acmd_pend.
- WAIT_ACMD success:
  - acmd12_status_o = 0, no interrupt pulse.
  - Go to IDLE; any pending driver command then issues.
- WAIT_ACMD fail:
  - acmd12_status_o = bit1 timeout | bit2 crc | bit3 end_bit | bit4 index.
  - Plus bit7 (command not issued) if drv_pend; clear drv_pend.
  - err_int_set_o bit8 pulses; driver error bits 0..3 are NOT set.
- Dropped driver commands produce no cmd_complete_set_o.
- acmd12_status_o holds its value until the next CMD12 completion or reset.
- cmd_inhibit_o = drv_pend | acmd_pend | (state != IDLE).
- Duplicate request while the same one is pending: ignored, flag stays set.
- Reset mid-operation: everything aborts to IDLE with status 0; no pulses are emitted.
- Latency:
  - Pending to seq_valid_o: 1 cycle.
  - rsp_valid_i to set pulses: 1 cycle, registered.

Decomposition:
- Package sdhci_pkg holds:
  - sdhci_cmd_t and sdhci_rsp_err_t.
  - rsp_type encodings (00 none, 01 136, 10 48, 11 48 busy).
  - Error-interrupt bit positions (TIMEOUT=0, CRC=1, END=2, INDEX=3, ACMD=8).
  - Auto CMD12 status bit positions (NOT_EXEC=0, TIMEOUT=1, CRC=2, END=3, INDEX=4, NOT_ISSUED=7).
- Single module, no sub-module.

Test Plan:
- acmd12_req_i and drv_cmd_valid_i (index 0) in the same cycle, both responses clean -> CMD12 issued first, then index 0; acmd12_status_o=0, err_int_set_o never nonzero, one cmd_complete_set_o.
- Driver command arrives 3 cycles before acmd12_req_i, clean responses -> driver command first, then CMD12; no errors.
- Simultaneous arrival, CMD12 response with crc+index errors -> driver command never offered; err_int_set_o=0x0100; acmd12_status_o=0x0094.
- Driver first, response crc+index error with CMD12 pending -> CMD12 never offered; err_int_set_o=0x010A; acmd12_status_o=0x0001.
- CMD12 arrives 2 cycles before driver, CMD12 times out -> acmd12_status_o=0x0082; err_int_set_o=0x0100.
- seq_ready_i held low 5 cycles, then rst_i pulsed -> seq_valid_o held stable throughout; after reset all outputs 0 and cmd_inhibit_o=0.

Source files
------------

// File: rtl/sdhci_acmd12_arbiter_pkg.sv
// Shared types and bit positions for the SDHCI command-issue arbiter.
package sdhci_pkg;

    typedef struct packed {
        logic [5:0]  index;
        logic [31:0] arg;
        logic [1:0]  rsp_type;
        logic        crc_chk;
        logic        idx_chk;
        logic        data_present;
    } sdhci_cmd_t;

    // timeout sits in bit0 so the struct reads naturally as a flag vector
    typedef struct packed {
        logic index;
        logic end_bit;
        logic crc;
        logic timeout;
    } sdhci_rsp_err_t;

    typedef enum logic [1:0] {
        RSP_NONE    = 2'b00,
        RSP_136     = 2'b01,
        RSP_48      = 2'b10,
        RSP_48_BUSY = 2'b11
    } rsp_type_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE_DRV,
        ST_WAIT_DRV,
        ST_ISSUE_ACMD,
        ST_WAIT_ACMD
    } arb_state_e;

    // Error Interrupt Status bit positions
    localparam int unsigned ERR_TIMEOUT = 0;
    localparam int unsigned ERR_CRC     = 1;
    localparam int unsigned ERR_END     = 2;
    localparam int unsigned ERR_INDEX   = 3;
    localparam int unsigned ERR_ACMD    = 8;

    // Auto CMD12 Error Status bit positions
    localparam int unsigned ACMD_NOT_EXEC   = 0;
    localparam int unsigned ACMD_TIMEOUT    = 1;
    localparam int unsigned ACMD_CRC        = 2;
    localparam int unsigned ACMD_END        = 3;
    localparam int unsigned ACMD_INDEX      = 4;
    localparam int unsigned ACMD_NOT_ISSUED = 7;

    function automatic logic rsp_failed(input sdhci_rsp_err_t e);
        return |e;
    endfunction

    // Driver-command response flags mapped onto Error Interrupt Status
    function automatic logic [15:0] drv_err_bits(input sdhci_rsp_err_t e);
        logic [15:0] v;
        v = '0;
        v[ERR_TIMEOUT] = e.timeout;
        v[ERR_CRC]     = e.crc;
        v[ERR_END]     = e.end_bit;
        v[ERR_INDEX]   = e.index;
        return v;
    endfunction

    // CMD12 response flags mapped onto Auto CMD12 Error Status
    function automatic logic [15:0] acmd_err_status(input sdhci_rsp_err_t e,
                                                    input logic not_issued);
        logic [15:0] v;
        v = '0;
        v[ACMD_TIMEOUT]    = e.timeout;
        v[ACMD_CRC]        = e.crc;
        v[ACMD_END]        = e.end_bit;
        v[ACMD_INDEX]      = e.index;
        v[ACMD_NOT_ISSUED] = not_issued;
        return v;
    endfunction

endpackage

// File: rtl/sdhci_acmd12_arbiter_if.sv
// Request/sequencer/response bundle between register file, arbiter and CMD sequencer.
interface sdhci_acmd12_arbiter_if;
    import sdhci_pkg::*;

    logic           drv_cmd_valid_i;
    sdhci_cmd_t     drv_cmd_i;
    logic           acmd12_req_i;
    logic           seq_valid_o;
    logic           seq_ready_i;
    sdhci_cmd_t     seq_cmd_o;
    logic           rsp_valid_i;
    sdhci_rsp_err_t rsp_err_i;
    logic           cmd_inhibit_o;
    logic [15:0]    acmd12_status_o;
    logic [15:0]    err_int_set_o;
    logic           cmd_complete_set_o;

    // arbiter side
    modport slave (
        input  drv_cmd_valid_i, drv_cmd_i, acmd12_req_i, seq_ready_i,
               rsp_valid_i, rsp_err_i,
        output seq_valid_o, seq_cmd_o, cmd_inhibit_o, acmd12_status_o,
               err_int_set_o, cmd_complete_set_o
    );

    // register file / sequencer side
    modport master (
        output drv_cmd_valid_i, drv_cmd_i, acmd12_req_i, seq_ready_i,
               rsp_valid_i, rsp_err_i,
        input  seq_valid_o, seq_cmd_o, cmd_inhibit_o, acmd12_status_o,
               err_int_set_o, cmd_complete_set_o
    );

endinterface

// File: rtl/sdhci_acmd12_arbiter.sv
// Orders driver commands and Auto CMD12, issues one at a time, reports CMD12 errors.
module sdhci_acmd12_arbiter
    import sdhci_pkg::*;
#(
    parameter logic [5:0] Acmd12Index = 6'd12
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    sdhci_acmd12_arbiter_if.slave bus
);

    arb_state_e  state;
    logic        drv_pend;
    logic        acmd_pend;
    sdhci_cmd_t  drv_cmd;
    logic [15:0] status;
    logic [15:0] err_set;
    logic        cc_set;

    logic        drv_now;
    logic        acmd_now;
    logic        fail;
    sdhci_cmd_t  acmd12_cmd;

    // Pending view including same-cycle arrivals, and the fixed CMD12 encoding
    always_comb begin
        drv_now                 = drv_pend | bus.drv_cmd_valid_i;
        acmd_now                = acmd_pend | bus.acmd12_req_i;
        fail                    = rsp_failed(bus.rsp_err_i);
        acmd12_cmd              = '0;
        acmd12_cmd.index        = Acmd12Index;
        acmd12_cmd.rsp_type     = RSP_48_BUSY;
        acmd12_cmd.crc_chk      = 1'b1;
        acmd12_cmd.idx_chk      = 1'b1;
        acmd12_cmd.data_present = 1'b0;
    end

    // Request capture, arbitration FSM and registered status/interrupt pulses
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            drv_pend  <= 1'b0;
            acmd_pend <= 1'b0;
            drv_cmd   <= '0;
            status    <= '0;
            err_set   <= '0;
            cc_set    <= 1'b0;
        end else begin
            err_set <= '0;
            cc_set  <= 1'b0;

            // A repeat write while still pending is absorbed; the first command stands.
            // Clears in the FSM below come later and therefore take priority.
            if (bus.drv_cmd_valid_i && !drv_pend) begin
                drv_pend <= 1'b1;
                drv_cmd  <= bus.drv_cmd_i;
            end
            if (bus.acmd12_req_i) begin
                acmd_pend <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (acmd_now) begin
                        state <= ST_ISSUE_ACMD;
                    end else if (drv_now) begin
                        state <= ST_ISSUE_DRV;
                    end
                end
                ST_ISSUE_DRV: begin
                    if (bus.seq_ready_i) begin
                        state    <= ST_WAIT_DRV;
                        drv_pend <= 1'b0;
                    end
                end
                ST_ISSUE_ACMD: begin
                    if (bus.seq_ready_i) begin
                        state     <= ST_WAIT_ACMD;
                        acmd_pend <= 1'b0;
                    end
                end
                ST_WAIT_DRV: begin
                    if (bus.rsp_valid_i) begin
                        state <= ST_IDLE;
                        if (!fail) begin
                            cc_set <= 1'b1;
                        end else begin
                            err_set <= drv_err_bits(bus.rsp_err_i);
                            if (acmd_now) begin
                                err_set[ERR_ACMD] <= 1'b1;
                                status            <= 16'(1 << ACMD_NOT_EXEC);
                                acmd_pend         <= 1'b0;
                            end
                        end
                    end
                end
                ST_WAIT_ACMD: begin
                    if (bus.rsp_valid_i) begin
                        state <= ST_IDLE;
                        if (!fail) begin
                            status <= '0;
                        end else begin
                            status            <= acmd_err_status(bus.rsp_err_i, drv_now);
                            err_set[ERR_ACMD] <= 1'b1;
                            drv_pend          <= 1'b0;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.seq_valid_o        = (state == ST_ISSUE_DRV) || (state == ST_ISSUE_ACMD);
    assign bus.seq_cmd_o          = (state == ST_ISSUE_ACMD) ? acmd12_cmd :
                                    (state == ST_ISSUE_DRV)  ? drv_cmd : '0;
    assign bus.cmd_inhibit_o      = drv_pend | acmd_pend | (state != ST_IDLE);
    assign bus.acmd12_status_o    = status;
    assign bus.err_int_set_o      = err_set;
    assign bus.cmd_complete_set_o = cc_set;

endmodule

// File: tb/tb_sdhci_acmd12_arbiter.sv
// Self-checking bench: directed vector table, hand sequences, randomized run vs reference model.
module tb_sdhci_acmd12_arbiter;
    import sdhci_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    sdhci_acmd12_arbiter_if bus();

    sdhci_acmd12_arbiter #(.Acmd12Index(6'd12)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic        rst;
        logic        dv;
        logic [5:0]  di;
        logic        rq;
        logic        rd;
        logic        rv;
        logic [3:0]  er;     // {index, end_bit, crc, timeout}
        logic        e_sv;
        logic [5:0]  e_idx;
        logic        e_inh;
        logic [15:0] e_st;
        logic [15:0] e_er;
        logic        e_cc;
    } vec_t;

    vec_t       tbl[$];
    sdhci_cmd_t exp12;

    // reference model state (transaction view: who owns the CMD line, was it accepted)
    int         m_owner;      // 0 nobody, 1 driver, 2 CMD12
    bit         m_granted;
    bit         m_dpend;
    bit         m_apend;
    sdhci_cmd_t m_dcmd;
    logic [15:0] m_status;
    logic [15:0] m_err;
    bit         m_cc;

    function automatic vec_t mk(string nm, logic r, logic dv, logic [5:0] di, logic rq,
                                logic rd, logic rv, logic [3:0] er, logic e_sv,
                                logic [5:0] e_idx, logic e_inh, logic [15:0] e_st,
                                logic [15:0] e_er, logic e_cc);
        vec_t v;
        v.nm = nm; v.rst = r; v.dv = dv; v.di = di; v.rq = rq; v.rd = rd; v.rv = rv;
        v.er = er; v.e_sv = e_sv; v.e_idx = e_idx; v.e_inh = e_inh; v.e_st = e_st;
        v.e_er = e_er; v.e_cc = e_cc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_all(input string nm, input logic e_sv, input logic [5:0] e_idx,
                             input logic e_inh, input logic [15:0] e_st,
                             input logic [15:0] e_er, input logic e_cc);
        chk({nm, ".seq_valid"}, 64'(bus.seq_valid_o), 64'(e_sv));
        if (e_sv) chk({nm, ".seq_idx"}, 64'(bus.seq_cmd_o.index), 64'(e_idx));
        chk({nm, ".inhibit"}, 64'(bus.cmd_inhibit_o), 64'(e_inh));
        chk({nm, ".status"}, 64'(bus.acmd12_status_o), 64'(e_st));
        chk({nm, ".err_set"}, 64'(bus.err_int_set_o), 64'(e_er));
        chk({nm, ".cc_set"}, 64'(bus.cmd_complete_set_o), 64'(e_cc));
    endtask

    // Drive one cycle of inputs, let the DUT consume them, return just after the edge
    task automatic apply(input logic r, input logic dv, input logic [5:0] di, input logic rq,
                         input logic rd, input logic rv, input logic [3:0] er);
        rst                       = r;
        bus.drv_cmd_valid_i       = dv;
        bus.drv_cmd_i             = '0;
        bus.drv_cmd_i.index       = di;
        bus.drv_cmd_i.arg         = 32'hC0DE_0000 | 32'(di);
        bus.drv_cmd_i.rsp_type    = RSP_48;
        bus.drv_cmd_i.crc_chk     = 1'b1;
        bus.drv_cmd_i.idx_chk     = 1'b1;
        bus.drv_cmd_i.data_present = di[0];
        bus.acmd12_req_i          = rq;
        bus.seq_ready_i           = rd;
        bus.rsp_valid_i           = rv;
        bus.rsp_err_i             = er;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string nm, input logic r, input logic dv, input logic [5:0] di,
                        input logic rq, input logic rd, input logic rv, input logic [3:0] er,
                        input logic e_sv, input logic [5:0] e_idx, input logic e_inh,
                        input logic [15:0] e_st, input logic [15:0] e_er, input logic e_cc);
        apply(r, dv, di, rq, rd, rv, er);
        check_all(nm, e_sv, e_idx, e_inh, e_st, e_er, e_cc);
    endtask

    // One clock of the reference model, evaluated from the inputs seen at the edge
    task automatic model_step();
        bit a_now, d_now, fail;
        sdhci_rsp_err_t e;
        e = bus.rsp_err_i;
        m_err = '0;
        m_cc  = 1'b0;
        if (rst) begin
            m_owner = 0; m_granted = 0; m_dpend = 0; m_apend = 0;
            m_dcmd = '0; m_status = '0;
            return;
        end
        a_now = m_apend | bus.acmd12_req_i;
        d_now = m_dpend | bus.drv_cmd_valid_i;
        if (bus.drv_cmd_valid_i && !m_dpend) begin
            m_dpend = 1;
            m_dcmd  = bus.drv_cmd_i;
        end
        if (bus.acmd12_req_i) m_apend = 1;
        if (m_owner == 0) begin
            m_owner   = a_now ? 2 : (d_now ? 1 : 0);
            m_granted = 0;
        end else if (!m_granted) begin
            if (bus.seq_ready_i) begin
                m_granted = 1;
                if (m_owner == 1) m_dpend = 0;
                else m_apend = 0;
            end
        end else if (bus.rsp_valid_i) begin
            fail = (e != 4'h0);
            if (m_owner == 1) begin
                if (!fail) begin
                    m_cc = 1;
                end else begin
                    m_err = 16'(e.timeout) + 16'(e.crc) * 2 + 16'(e.end_bit) * 4 + 16'(e.index) * 8;
                    if (a_now) begin
                        m_err    = m_err + 16'h0100;
                        m_status = 16'h0001;
                        m_apend  = 0;
                    end
                end
            end else begin
                if (!fail) begin
                    m_status = 16'h0000;
                end else begin
                    m_status = 16'(e.timeout) * 2 + 16'(e.crc) * 4 + 16'(e.end_bit) * 8
                             + 16'(e.index) * 16 + (d_now ? 16'h0080 : 16'h0000);
                    m_err    = 16'h0100;
                    m_dpend  = 0;
                end
            end
            m_owner = 0;
        end
    endtask

    initial begin
        logic [63:0] r64;
        logic        e_sv;
        n_cmp  = 0;
        n_fail = 0;
        exp12  = '{index: 6'd12, arg: 32'h0, rsp_type: 2'b11, crc_chk: 1'b1,
                   idx_chk: 1'b1, data_present: 1'b0};
        rst = 1'b1;
        bus.drv_cmd_valid_i = 1'b0; bus.drv_cmd_i = '0; bus.acmd12_req_i = 1'b0;
        bus.seq_ready_i = 1'b0; bus.rsp_valid_i = 1'b0; bus.rsp_err_i = '0;
        @(posedge clk);
        #1;

        // simultaneous arrival, clean responses: CMD12 first, then driver index 0
        tbl.push_back(mk("s1_rst",   1,0,6'd0,0,0,0,4'h0, 0,6'd0, 0,16'h0,16'h0,0));
        tbl.push_back(mk("s1_both",  0,1,6'd0,1,0,0,4'h0, 1,6'd12,1,16'h0,16'h0,0));
        tbl.push_back(mk("s1_acc12", 0,0,6'd0,0,1,0,4'h0, 0,6'd0, 1,16'h0,16'h0,0));
        tbl.push_back(mk("s1_rsp12", 0,0,6'd0,0,0,1,4'h0, 0,6'd0, 1,16'h0,16'h0,0));
        tbl.push_back(mk("s1_iss0",  0,0,6'd0,0,0,0,4'h0, 1,6'd0, 1,16'h0,16'h0,0));
        tbl.push_back(mk("s1_acc0",  0,0,6'd0,0,1,0,4'h0, 0,6'd0, 1,16'h0,16'h0,0));
        tbl.push_back(mk("s1_rsp0",  0,0,6'd0,0,0,1,4'h0, 0,6'd0, 0,16'h0,16'h0,1));
        tbl.push_back(mk("s1_idle",  0,0,6'd0,0,0,0,4'h0, 0,6'd0, 0,16'h0,16'h0,0));
        // simultaneous arrival, CMD12 crc+index failure: driver command dropped
        tbl.push_back(mk("s3_both",  0,1,6'd3,1,0,0,4'h0, 1,6'd12,1,16'h0,16'h0,0));
        tbl.push_back(mk("s3_acc12", 0,0,6'd0,0,1,0,4'h0, 0,6'd0, 1,16'h0,16'h0,0));
        tbl.push_back(mk("s3_rsp12", 0,0,6'd0,0,0,1,4'hA, 0,6'd0, 0,16'h0094,16'h0100,0));
        tbl.push_back(mk("s3_idle1", 0,0,6'd0,0,1,0,4'h0, 0,6'd0, 0,16'h0094,16'h0,0));
        tbl.push_back(mk("s3_idle2", 0,0,6'd0,0,1,0,4'h0, 0,6'd0, 0,16'h0094,16'h0,0));

        foreach (tbl[i]) begin
            step(tbl[i].nm, tbl[i].rst, tbl[i].dv, tbl[i].di, tbl[i].rq, tbl[i].rd,
                 tbl[i].rv, tbl[i].er, tbl[i].e_sv, tbl[i].e_idx, tbl[i].e_inh,
                 tbl[i].e_st, tbl[i].e_er, tbl[i].e_cc);
        end

        // driver 3 cycles ahead of CMD12, clean responses
        step("s2_rst",  1,0,6'd0,0,0,0,4'h0, 0,6'd0, 0,16'h0,16'h0,0);
        step("s2_drv",  0,1,6'd5,0,0,0,4'h0, 1,6'd5, 1,16'h0,16'h0,0);
        step("s2_w1",   0,0,6'd0,0,0,0,4'h0, 1,6'd5, 1,16'h0,16'h0,0);
        step("s2_w2",   0,0,6'd0,0,0,0,4'h0, 1,6'd5, 1,16'h0,16'h0,0);
        step("s2_req",  0,0,6'd0,1,0,0,4'h0, 1,6'd5, 1,16'h0,16'h0,0);
        step("s2_acc5", 0,0,6'd0,0,1,0,4'h0, 0,6'd0, 1,16'h0,16'h0,0);
        step("s2_rsp5", 0,0,6'd0,0,0,1,4'h0, 0,6'd0, 1,16'h0,16'h0,1);
        step("s2_iss12",0,0,6'd0,0,0,0,4'h0, 1,6'd12,1,16'h0,16'h0,0);
        chk("s2_cmd12_fmt", 64'(bus.seq_cmd_o), 64'(exp12));
        step("s2_acc12",0,0,6'd0,0,1,0,4'h0, 0,6'd0, 1,16'h0,16'h0,0);
        step("s2_rsp12",0,0,6'd0,0,0,1,4'h0, 0,6'd0, 0,16'h0,16'h0,0);
        step("s2_idle", 0,0,6'd0,0,0,0,4'h0, 0,6'd0, 0,16'h0,16'h0,0);

        // driver first, crc+index failure with CMD12 pending: CMD12 not executed
        step("s4_rst",  1,0,6'd0,0,0,0,4'h0, 0,6'd0, 0,16'h0,16'h0,0);
        step("s4_drv",  0,1,6'd7,0,0,0,4'h0, 1,6'd7, 1,16'h0,16'h0,0);
        step("s4_req",  0,0,6'd0,1,0,0,4'h0, 1,6'd7, 1,16'h0,16'h0,0);
        step("s4_acc7", 0,0,6'd0,0,1,0,4'h0, 0,6'd0, 1,16'h0,16'h0,0);
        step("s4_rsp7", 0,0,6'd0,0,0,1,4'hA, 0,6'd0, 0,16'h0001,16'h010A,0);
        step("s4_idle1",0,0,6'd0,0,1,0,4'h0, 0,6'd0, 0,16'h0001,16'h0,0);
        step("s4_idle2",0,0,6'd0,0,1,0,4'h0, 0,6'd0, 0,16'h0001,16'h0,0);

        // CMD12 2 cycles ahead of driver, CMD12 timeout: driver not issued
        step("s5_rst",  1,0,6'd0,0,0,0,4'h0, 0,6'd0, 0,16'h0,16'h0,0);
        step("s5_req",  0,0,6'd0,1,0,0,4'h0, 1,6'd12,1,16'h0,16'h0,0);
        step("s5_w1",   0,0,6'd0,0,0,0,4'h0, 1,6'd12,1,16'h0,16'h0,0);
        step("s5_drv",  0,1,6'd9,0,0,0,4'h0, 1,6'd12,1,16'h0,16'h0,0);
        step("s5_acc12",0,0,6'd0,0,1,0,4'h0, 0,6'd0, 1,16'h0,16'h0,0);
        step("s5_rsp12",0,0,6'd0,0,0,1,4'h1, 0,6'd0, 0,16'h0082,16'h0100,0);
        step("s5_idle", 0,0,6'd0,0,1,0,4'h0, 0,6'd0, 0,16'h0082,16'h0,0);

        // stalled sequencer, duplicate write ignored, reset mid-issue clears everything
        step("s6_rst",  1,0,6'd0,0,0,0,4'h0, 0,6'd0, 0,16'h0,16'h0,0);
        step("s6_drv",  0,1,6'd33,0,0,0,4'h0, 1,6'd33,1,16'h0,16'h0,0);
        step("s6_h1",   0,0,6'd0,0,0,0,4'h0, 1,6'd33,1,16'h0,16'h0,0);
        step("s6_dup",  0,1,6'd44,0,0,0,4'h0, 1,6'd33,1,16'h0,16'h0,0);
        step("s6_h3",   0,0,6'd0,0,0,1,4'h0, 1,6'd33,1,16'h0,16'h0,0);
        step("s6_h4",   0,0,6'd0,0,0,0,4'h0, 1,6'd33,1,16'h0,16'h0,0);
        step("s6_h5",   0,0,6'd0,0,0,0,4'h0, 1,6'd33,1,16'h0,16'h0,0);
        step("s6_mrst", 1,0,6'd0,0,0,0,4'h0, 0,6'd0, 0,16'h0,16'h0,0);
        step("s6_after",0,0,6'd0,0,1,1,4'hF, 0,6'd0, 0,16'h0,16'h0,0);

        // randomized traffic against the reference model
        for (int c = 0; c < 3000; c++) begin
            rst                 = (c == 0) || ($urandom_range(0, 399) == 0);
            bus.drv_cmd_valid_i = ($urandom_range(0, 7) == 0);
            r64                 = {$urandom, $urandom};
            bus.drv_cmd_i       = r64[42:0];
            bus.acmd12_req_i    = ($urandom_range(0, 9) == 0);
            bus.seq_ready_i     = ($urandom_range(0, 1) == 1);
            bus.rsp_valid_i     = ($urandom_range(0, 3) == 0);
            bus.rsp_err_i       = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0;
            @(posedge clk);
            model_step();
            #1;
            e_sv = (m_owner != 0) && !m_granted;
            chk("rnd.seq_valid", 64'(bus.seq_valid_o), 64'(e_sv));
            if (e_sv) chk("rnd.seq_cmd", 64'(bus.seq_cmd_o), (m_owner == 2) ? 64'(exp12) : 64'(m_dcmd));
            chk("rnd.inhibit", 64'(bus.cmd_inhibit_o), 64'(m_dpend | m_apend | (m_owner != 0)));
            chk("rnd.status", 64'(bus.acmd12_status_o), 64'(m_status));
            chk("rnd.err_set", 64'(bus.err_int_set_o), 64'(m_err));
            chk("rnd.cc_set", 64'(bus.cmd_complete_set_o), 64'(m_cc));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
